uart_rx: RTL and testbench

- Serial receiver: the downstream partner of the team's UART transmitter.
- Consumes the 8N1 serial line driven by the transmitter's tx output.
- Recovers each byte by mid-bit sampling on a clock-count baud timer, then presents it as a parallel word with a one-cycle valid strobe.
- Flags framing errors and holds off a new frame until the line returns to idle after a break.

---
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling, framing-error detection
// and a break hold-off state that waits for the line to return idle.
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
   localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StBreak
   } state_e;

   state_e                 state_q, state_d;
   logic                   rx_meta_q, rx_s_q;
   logic [CntW-1:0]        clk_cnt_q, clk_cnt_d;
   logic [IdxW-1:0]        bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   frame_err_q, frame_err_d;

   // Two-flop synchronizer; preset high so reset looks like an idle line.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // State, counters and registered output strobes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         clk_cnt_q   <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         clk_cnt_q   <= clk_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Next-state: half-bit wait to the start-bit centre, then whole-bit steps.
   always_comb begin
      state_d     = state_q;
      clk_cnt_d   = clk_cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!rx_s_q) begin
               state_d   = StStart;
               clk_cnt_d = '0;
            end
         end
         StStart: begin
            if (clk_cnt_q == HalfLast) begin
               clk_cnt_d = '0;
               bit_idx_d = '0;
               // A start bit that is high again at its centre is a glitch.
               state_d   = rx_s_q ? StIdle : StData;
            end else begin
               clk_cnt_d = clk_cnt_q + CntW'(1);
            end
         end
         StData: begin
            if (clk_cnt_q == BitLast) begin
               clk_cnt_d          = '0;
               shift_d[bit_idx_q] = rx_s_q;
               if (bit_idx_q == IdxLast) begin
                  state_d = StStop;
               end else begin
                  bit_idx_d = bit_idx_q + IdxW'(1);
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CntW'(1);
            end
         end
         StStop: begin
            if (clk_cnt_q == BitLast) begin
               clk_cnt_d = '0;
               if (rx_s_q) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = StIdle;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = StBreak;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CntW'(1);
            end
         end
         StBreak: begin
            if (rx_s_q) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs come straight from registers; busy follows the state.
   always_comb begin
      data      = data_q;
      valid     = valid_q;
      frame_err = frame_err_q;
      busy      = (state_q != StIdle);
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx; stimulus pushes expected strobes,
// a negedge monitor pops and compares them as the receiver emits them.
module tb_uart_rx;

   localparam int unsigned Cpb    = 16;
   localparam int          LatMin = 152;
   localparam int          LatMax = 164;

   logic       clk;
   logic       reset;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;

   typedef struct {
      bit         err;
      logic [7:0] data;
      int         start;
   } ev_t;

   ev_t        exp_q[$];
   int         checks;
   int         errors;
   int         cyc;
   logic [7:0] last_good;

   uart_rx #(
      .CLKS_PER_BIT(Cpb),
      .DATA_BITS   (8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .rx       (rx),
      .data     (data),
      .valid    (valid),
      .frame_err(frame_err),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one full frame; the expected strobe is queued at the start edge.
   task automatic send_frame(input logic [7:0] b, input logic stop_b);
      ev_t e;
      e.err   = !stop_b;
      e.data  = b;
      e.start = cyc;
      exp_q.push_back(e);
      rx = 1'b0;
      tick(Cpb);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(Cpb);
      end
      rx = stop_b;
      tick(Cpb);
   endtask

   // Monitor: every strobe must match the head of the expectation queue.
   always @(negedge clk) begin
      if (valid && frame_err) begin
         check("valid_and_frame_err_exclusive", 32'd1, 32'd0);
      end
      if (valid || frame_err) begin
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", {30'd0, frame_err, valid}, 32'd0);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            check("strobe_kind_is_err", {31'd0, frame_err}, {31'd0, e.err});
            check("strobe_latency_in_window",
                  {31'd0, ((cyc - e.start) >= LatMin) && ((cyc - e.start) <= LatMax)}, 32'd1);
            check("busy_low_on_valid", {31'd0, busy}, {31'd0, e.err});
            if (e.err) begin
               check("data_held_on_frame_err", {24'd0, data}, {24'd0, last_good});
            end else begin
               check("data_on_valid", {24'd0, data}, {24'd0, e.data});
               last_good = e.data;
            end
         end
      end
   end

   initial begin
      checks    = 0;
      errors    = 0;
      cyc       = 0;
      last_good = 8'h00;
      reset     = 1'b0;
      rx        = 1'b1;

      // Reset held with the line toggling: outputs stay at their reset values.
      for (int i = 0; i < 6; i++) begin
         rx = i[0];
         tick(1);
         check("reset_data", {24'd0, data}, 32'd0);
         check("reset_busy", {31'd0, busy}, 32'd0);
         check("reset_strobes", {30'd0, valid, frame_err}, 32'd0);
      end
      rx = 1'b1;
      tick(2);
      reset = 1'b1;
      tick(20);
      check("idle_after_reset_busy", {31'd0, busy}, 32'd0);

      // Single byte with busy probed early in the frame.
      fork
         send_frame(8'hA5, 1'b1);
         begin
            tick(5);
            check("busy_early_in_frame", {31'd0, busy}, 32'd1);
         end
      join
      tick(Cpb);

      // Back-to-back frames, no idle gap.
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      tick(Cpb);

      // Framing error: stop bit low and the line held low three bit times.
      send_frame(8'h3C, 1'b0);
      tick(Cpb);
      check("busy_held_in_break", {31'd0, busy}, 32'd1);
      tick(Cpb);
      check("busy_still_held_in_break", {31'd0, busy}, 32'd1);
      rx = 1'b1;
      tick(Cpb);
      check("busy_released_after_break", {31'd0, busy}, 32'd0);
      send_frame(8'h81, 1'b1);
      tick(Cpb);

      // Start glitch shorter than half a bit.
      rx = 1'b0;
      tick(3);
      rx = 1'b1;
      tick(3);
      check("glitch_busy_seen", {31'd0, busy}, 32'd1);
      tick(6);
      check("glitch_busy_cleared", {31'd0, busy}, 32'd0);
      tick(Cpb);

      // Mid-frame reset during data bit 4 of 0x5A; no strobe may follow.
      rx = 1'b0;
      tick(Cpb);
      for (int i = 0; i < 4; i++) begin
         rx = 8'h5A >> i;
         tick(Cpb);
      end
      rx = 1'b1;
      tick(Cpb / 2);
      reset = 1'b0;
      tick(1);
      check("mid_reset_data_cleared", {24'd0, data}, 32'd0);
      check("mid_reset_busy_cleared", {31'd0, busy}, 32'd0);
      last_good = 8'h00;
      tick(2);
      reset = 1'b1;
      tick(2 * Cpb);
      check("after_mid_reset_idle", {31'd0, busy}, 32'd0);
      send_frame(8'hC3, 1'b1);

      // Bounded drain: every queued strobe must have appeared by now.
      tick(3 * Cpb);
      check("all_expected_strobes_seen", exp_q.size(), 32'd0);
      check("final_data", {24'd0, data}, 32'hC3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
